// File: rtl/instr_feeder_if.sv
// Handshake bundle between the instruction loader / processor side and instr_feeder.
// Carries the FIFO write channel and the tick-synchronous instruction output.
interface instr_feeder_if;
    logic       wr_valid;
    logic [8:0] wr_data;
    logic       wr_ready;
    logic [3:0] tick;
    logic [8:0] din;

    modport master (
        output wr_valid,
        output wr_data,
        output tick,
        input  wr_ready,
        input  din
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  tick,
        output wr_ready,
        output din
    );
endinterface

// File: rtl/instr_feeder.sv
// Instruction FIFO that feeds simple_proc's din in step with its one-hot tick,
// issuing whole instructions only and substituting NOPs otherwise.
module instr_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    instr_feeder_if.slave bus,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic [15:0]   issued,
    output logic          seq_err
);

    typedef enum logic {ST_ISSUE, ST_IMM} state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    head;
    logic          push;
    logic          pop;
    logic          head_ready;
    logic          to_imm;
    logic          to_issue;
    logic          set_err;
    logic          issue_now;
    logic [8:0]    din_c;

    function automatic logic is_two_word(input logic [8:0] w);
        return (w[8:6] == 3'b111) || (w[8:6] == 3'b010);
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.wr_valid && !full;

    assign bus.wr_ready = !full;
    assign bus.din      = din_c;

    // A two-word instruction only counts as ready once its immediate is buffered too.
    assign head_ready = is_two_word(head) ? (count >= (AW+1)'(2)) : (count != '0);

    always_comb begin
        din_c     = 9'd0;
        pop       = 1'b0;
        to_imm    = 1'b0;
        to_issue  = 1'b0;
        set_err   = 1'b0;
        issue_now = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (bus.tick == 4'b1000 && head_ready) begin
                    din_c     = head;
                    pop       = 1'b1;
                    issue_now = 1'b1;
                    to_imm    = is_two_word(head);
                end
            end
            ST_IMM: begin
                case (bus.tick)
                    4'b0001, 4'b0010: din_c = head;
                    4'b0100: begin
                        din_c    = head;
                        pop      = 1'b1;
                        to_issue = 1'b1;
                    end
                    default: begin
                        // Out-of-order tick: drop the immediate so the stream realigns.
                        pop      = 1'b1;
                        set_err  = 1'b1;
                        to_issue = 1'b1;
                    end
                endcase
            end
            default: din_c = 9'd0;
        endcase
    end

    // FIFO storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_ISSUE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            issued  <= '0;
            seq_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (issue_now) begin
                issued <= issued + 16'd1;
            end
            if (set_err) begin
                seq_err <= 1'b1;
            end
            if (to_imm) begin
                state <= ST_IMM;
            end else if (to_issue) begin
                state <= ST_ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Randomised and directed bench for instr_feeder against a queue-based model of the
// instruction stream, with literal spot checks on the documented scenarios.
module tb_instr_feeder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic [15:0]   issued;
    logic          seq_err;

    instr_feeder_if bus ();

    instr_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .issued  (issued),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [8:0]  q[$];
    logic        m_imm;
    logic [15:0] m_issued;
    logic        m_err;
    logic [8:0]  last_din;

    function automatic logic two_word(input logic [8:0] w);
        return (w[8:6] == 3'b111) || (w[8:6] == 3'b010);
    endfunction

    function automatic logic m_ready();
        if (q.size() == 0) return 1'b0;
        if (two_word(q[0])) return q.size() >= 2;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_imm    = 1'b0;
        m_issued = '0;
        m_err    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"},      bus.din, 9'd0);
        chk({tag, "_wr_ready"}, bus.wr_ready, 1);
        chk({tag, "_empty"},    empty, 1);
        chk({tag, "_full"},     full, 0);
        chk({tag, "_count"},    count, 0);
        chk({tag, "_issued"},   issued, 0);
        chk({tag, "_seq_err"},  seq_err, 0);
    endtask

    // One clock cycle: drive, compare against the model, then advance the model at the edge.
    task automatic step(input logic wv, input logic [8:0] wd, input logic [3:0] tk);
        logic [8:0] e_din;
        logic       pop, push, go_imm, err, iss;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.tick     = tk;
        #1;
        e_din  = 9'd0;
        pop    = 1'b0;
        err    = 1'b0;
        iss    = 1'b0;
        go_imm = m_imm;
        push   = wv && (q.size() < DEPTH);
        if (!m_imm) begin
            if (tk == 4'b1000 && m_ready()) begin
                e_din  = q[0];
                pop    = 1'b1;
                iss    = 1'b1;
                go_imm = two_word(q[0]);
            end
        end else begin
            if (tk == 4'b0001 || tk == 4'b0010) begin
                e_din = q[0];
            end else if (tk == 4'b0100) begin
                e_din  = q[0];
                pop    = 1'b1;
                go_imm = 1'b0;
            end else begin
                pop    = 1'b1;
                err    = 1'b1;
                go_imm = 1'b0;
            end
        end
        chk("din",      bus.din, e_din);
        chk("wr_ready", bus.wr_ready, q.size() < DEPTH);
        chk("count",    count, q.size());
        chk("empty",    empty, q.size() == 0);
        chk("full",     full, q.size() == DEPTH);
        chk("issued",   issued, m_issued);
        chk("seq_err",  seq_err, m_err);
        last_din = bus.din;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(wd);
        if (iss) m_issued++;
        if (err) m_err = 1'b1;
        m_imm = go_imm;
        #1;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.tick     = 4'b0000;
        #2 rst = 1'b0;
        #1;
        chk_reset_vals(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] tk;
        logic [3:0] rot [4];
        int         ri;
        rot[0] = 4'b1000; rot[1] = 4'b0001; rot[2] = 4'b0010; rot[3] = 4'b0100;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.tick     = 4'b0000;
        rst          = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;

        // One-word instruction
        step(1'b1, 9'o101, 4'b0000);
        step(1'b0, 9'd0, 4'b1000);
        chk("onew_din", last_din, 9'o101);
        chk("onew_issued", issued, 1);
        chk("onew_count", count, 0);
        step(1'b0, 9'd0, 4'b1000);
        chk("onew_nop", last_din, 9'd0);

        // movi with immediate
        step(1'b1, 9'o700, 4'b0000);
        step(1'b1, 9'h005, 4'b0000);
        chk("movi_count2", count, 2);
        step(1'b0, 9'd0, 4'b1000);
        chk("movi_ir", last_din, 9'o700);
        chk("movi_count1", count, 1);
        step(1'b0, 9'd0, 4'b0001);
        chk("movi_imm1", last_din, 9'h005);
        step(1'b0, 9'd0, 4'b0010);
        step(1'b0, 9'd0, 4'b0100);
        chk("movi_imm3", last_din, 9'h005);
        chk("movi_count0", count, 0);
        step(1'b0, 9'd0, 4'b1000);
        chk("movi_nop", last_din, 9'd0);

        // Incomplete two-word instruction
        step(1'b1, 9'o210, 4'b0000);
        repeat (3) step(1'b0, 9'd0, 4'b1000);
        chk("inc_nop", last_din, 9'd0);
        chk("inc_count", count, 1);
        step(1'b1, 9'h1FF, 4'b0000);
        step(1'b0, 9'd0, 4'b1000);
        chk("inc_ir", last_din, 9'o210);
        step(1'b0, 9'd0, 4'b0001);
        step(1'b0, 9'd0, 4'b0010);
        step(1'b0, 9'd0, 4'b0100);
        chk("inc_imm", last_din, 9'h1FF);

        // Full and wrap-around
        for (int i = 0; i < DEPTH; i++) step(1'b1, 9'(9'o010 + i), 4'b0000);
        chk("full_flag", full, 1);
        chk("full_ready", bus.wr_ready, 0);
        step(1'b1, 9'o777, 4'b0000);
        chk("full_ignored", count, DEPTH);
        for (int i = 0; i < 3; i++) step(1'b1, 9'(9'o030 + i), 4'b1000);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 9'd0, 4'b1000);
        chk("wrap_drained", count, 0);

        // Sequence error
        step(1'b1, 9'o720, 4'b0000);
        step(1'b1, 9'h033, 4'b0000);
        step(1'b0, 9'd0, 4'b1000);
        step(1'b0, 9'd0, 4'b0001);
        step(1'b0, 9'd0, 4'b1000);
        chk("seq_din", last_din, 9'd0);
        chk("seq_err_set", seq_err, 1);
        chk("seq_popped", count, 0);
        step(1'b0, 9'd0, 4'b0100);
        chk("seq_err_sticky", seq_err, 1);

        // Reset mid-IMM with three words still held
        step(1'b1, 9'o700, 4'b0000);
        step(1'b1, 9'h005, 4'b0000);
        step(1'b1, 9'o101, 4'b0000);
        step(1'b1, 9'o102, 4'b0000);
        step(1'b0, 9'd0, 4'b1000);
        step(1'b0, 9'd0, 4'b0001);
        chk("mid_count3", count, 3);
        async_reset("midrst");
        step(1'b0, 9'd0, 4'b0010);

        // Randomised traffic: mostly legal tick rotation with occasional glitches and resets
        ri = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) tk = 4'($urandom_range(0, 15));
            else begin
                tk = rot[ri];
                ri = (ri + 1) % 4;
            end
            step($urandom_range(0, 9) < 6, 9'($urandom_range(0, 511)), tk);
            if ($urandom_range(0, 599) == 0) async_reset("rndrst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_feeder.md
# instr_feeder

Upstream instruction source for `simple_proc`. A loader writes 9-bit words into an internal FIFO. The block drives the processor's `din` in lock-step with the processor's one-hot `tick`:
- instruction words are presented on the IR-load tick;
- the immediate word of `movi`/`addi` is presented during that instruction's execute ticks;
- a NOP (9'b000000000) is substituted whenever a complete instruction is not yet buffered.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `AW`, 3: pointer width, log2(DEPTH).

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `wr_valid` input, 1: loader offers `wr_data`.
- `wr_data` input, 9: instruction or immediate word.
- `wr_ready` output, 1: FIFO can accept a word; equals `!full`.
- `tick` input, 4: processor tick, one-hot 0001/0010/0100/1000.
- `din` output, 9: word to the processor `din`.
- `count` output, AW+1: words held in the FIFO.
- `empty` output, 1: `count == 0`.
- `full` output, 1: `count == DEPTH`.
- `issued` output, 16: number of real (non-NOP) instructions issued.
- `seq_err` output, 1: sticky flag, tick sequence violated while an immediate was pending.

## Operation
- **Two-word opcodes:**
  - `IR[8:6]` = 3'b111 (`movi`) or 3'b010 (`addi`) is a two-word instruction: the instruction word is followed in the FIFO by its immediate.
  - All other opcodes are one-word.
- **Write side:**
  - A push occurs on a rising edge with `wr_valid && wr_ready`: `mem[wr_ptr] <= wr_data`, and `wr_ptr` increments modulo DEPTH.
  - There is no bypass. A word is visible on `din` no earlier than the cycle after it is written.
- **FSM states:** ISSUE and IMM. Reset state is ISSUE.
- **ISSUE, `tick == 4'b1000`** (the issue tick):
  - Let `head = mem[rd_ptr]`.
  - The instruction is ready if `count ≥ 1` and head is one-word, or `count ≥ 2` and head is two-word.
  - If ready: `din = head`, pop on the edge, `issued` increments. If head is two-word, go to IMM; otherwise stay in ISSUE.
  - If not ready: `din = 9'b0` (NOP), no pop, `issued` unchanged.
- **ISSUE, any other tick value** (including 0000 or non-one-hot): `din = 9'b0`, no pop.
- **IMM:**
  - `din = mem[rd_ptr]` (the immediate), held while tick is 0001, 0010 or 0100.
  - On the edge where `tick == 4'b0100`: pop, return to ISSUE.
  - If `tick == 4'b1000` or a non-one-hot value occurs while in IMM: pop the immediate, set `seq_err`, return to ISSUE. `din = 9'b0` that cycle.
- **Pointers and counter:**
  - Each pop increments `rd_ptr` modulo DEPTH.
  - `count` increments on a push alone, decrements on a pop alone, and is unchanged on a simultaneous push and pop.
- **`issued`** wraps from 16'hFFFF to 0.
- **`seq_err`** is cleared only by reset.

## Timing
- `din` is combinational from state, `tick`, `count` and `mem[rd_ptr]`. It is valid in the same cycle as `tick`, so the processor's IR captures it on the edge that ends tick 1000.
- `wr_ready`, `full`, `empty` and `count` are derived from registered state only, with no combinational path from `wr_valid`.
- Push when full is impossible because `wr_ready = 0`.
- Simultaneous push and pop at `count == DEPTH-1` or with `count` at an intermediate value are both legal.
- **Reset** (asynchronous, `rst = 0`):
  - state = ISSUE; `wr_ptr`, `rd_ptr`, `count`, `issued`, `seq_err` = 0;
  - `wr_ready = 1`, `empty = 1`, `full = 0`;
  - `din = 9'b0`.
  - FIFO contents are not cleared.
- Reset asserted mid-IMM discards the pending immediate.
- Latency: a one-word instruction written at edge N can issue at the first tick 1000 that is ≥ 1 cycle later.

## Test plan
- **One-word instruction:** reset, push 9'b001_000_001 (add R0,R1), drive tick 1000 → `din` = 9'o101, pop, `issued` = 1, `count` = 0, next tick 1000 → `din` = 0.
- **`movi` with immediate:** push 9'o700 then 9'h005, cycle ticks 1000,0001,0010,0100,1000 → `din` = 9'o700, 005, 005, 005, 0; `count` 2→1→0 at the 1000 and 0100 edges.
- **Incomplete two-word instruction:** push 9'o210 only, tick 1000 repeatedly → `din` stays 0, `count` = 1, `issued` = 0; push immediate 9'h1FF → next tick 1000 issues 9'o210, then `din` = 9'h1FF through tick 0100.
- **Full and wrap-around:** push 8 words → `full` = 1, `wr_ready` = 0; an extra `wr_valid` is ignored; issue 3 one-word instructions and push 3 more → order preserved across pointer wrap.
- **Sequence error:** in IMM, drive tick 1000 instead of 0100 → `seq_err` = 1 and stays 1, immediate popped, `din` = 0 that cycle, state returns to ISSUE.
- **Reset mid-operation:** in IMM with `count` = 3, assert `rst` asynchronously between edges → all outputs take reset values immediately, `count` = 0, `din` = 0.
